// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register-file read-port arbiter.
package regfile_pkg;

    localparam int NREQ = 4;  // number of requesters (logic sized for exactly 4)
    localparam int AW   = 2;  // register index width / read-mux select width
    localparam int DW   = 4;  // register data width
    localparam int IDW  = 2;  // requester id width

    // 2'b11 is not a legal state; the FSM falls back to IDLE from it.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Bundle of request, read-mux and response signals around the read arbiter.
// slave: the arbiter side. master: requesters, read mux and response consumer.
interface regfile_read_arbiter_if;
    import regfile_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      rd_sel;
    logic [DW-1:0]      rd_data;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [DW-1:0]      resp_data;
    logic               busy;

    modport slave (
        input  req, req_addr, rd_data, resp_ready,
        output gnt, rd_sel, resp_valid, resp_id, resp_data, busy
    );

    modport master (
        output req, req_addr, rd_data, resp_ready,
        input  gnt, rd_sel, resp_valid, resp_id, resp_data, busy
    );

endinterface

// File: rtl/regfile_read_arbiter_rr_pick4.sv
// Combinational 4-way round-robin pick: first set request scanning from ptr.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] winner_o,
    output logic       any_o
);

    // Requests rotated so that rot[0] is the requester at ptr.
    logic [3:0] rot;
    logic [1:0] off;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot[gi] = req_i[ptr_i + 2'(gi)];
    end

    // Lowest rotated offset wins; winner is that offset added back onto ptr.
    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign winner_o = ptr_i + off;
    assign any_o    = |req_i;

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the register file's single read port.
// IDLE picks a winner, READ drives the mux select for one cycle and captures
// the data, RESP holds the tagged response until the consumer accepts it.
module regfile_read_arbiter
    import regfile_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    regfile_read_arbiter_if.slave  bus
);

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   rd_sel_q, rd_sel_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;

    logic [1:0]      winner;
    logic            any_req;

    rr_pick4 u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // Next-state and registered-output logic for the IDLE/READ/RESP sequence.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        gnt_d        = '0;
        rd_sel_d     = rd_sel_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            IDLE: begin
                resp_valid_d = 1'b0;
                if (any_req) begin
                    // rd_sel doubles as the latched register address.
                    id_d          = winner;
                    rd_sel_d      = bus.req_addr[AW*winner +: AW];
                    gnt_d[winner] = 1'b1;
                    ptr_d         = winner + 2'd1;
                    state_d       = READ;
                end
            end
            READ: begin
                resp_data_d  = bus.rd_data;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            gnt_q        <= '0;
            rd_sel_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            gnt_q        <= gnt_d;
            rd_sel_q     <= rd_sel_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rd_sel     = rd_sel_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for the register-file read arbiter.
// Expected grants and responses are queued when requests are posted and
// compared as the arbiter issues grants and completes response handshakes.
module tb_regfile_read_arbiter;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_read_arbiter_if ifc ();

    regfile_read_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // Register file contents behind the 4:1 read mux.
    logic [DW-1:0] regs [4];
    assign ifc.rd_data = regs[ifc.rd_sel];

    typedef struct { logic [1:0] id; logic [1:0] addr; } gexp_t;
    typedef struct { logic [1:0] id; logic [3:0] data; } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   gnt_cnt  = 0;
    int   last_gnt_cyc = -1;
    bit   spacing_en = 1'b0;
    bit   auto_drop  = 1'b1;
    int   hold_cnt   = 0;
    logic [1:0] mptr = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference round-robin choice: first set bit scanning p, p+1, ...
    function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] p);
        logic [1:0] idx;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (m[idx]) return idx;
        end
        return p;
    endfunction

    function automatic logic [1:0] addr_of(input logic [1:0] id);
        logic [7:0] a;
        a = ifc.req_addr;
        return a[2*id +: 2];
    endfunction

    // Raise requests and predict the order in which they get served.
    task automatic post(input logic [3:0] m);
        logic [3:0] rem;
        logic [1:0] w;
        logic [1:0] a;
        ifc.req = ifc.req | m;
        rem = m;
        while (rem != 4'd0) begin
            w = pick(rem, mptr);
            a = addr_of(w);
            gq.push_back('{w, a});
            rq.push_back('{w, regs[a]});
            $display("post req=%b -> expect grant id=%0d addr=%0d data=%0h", m, w, a, regs[a]);
            rem[w] = 1'b0;
            mptr = w + 2'd1;
        end
    endtask

    // Requests held high across n grants.
    task automatic post_held(input logic [3:0] m, input int n);
        logic [1:0] w;
        logic [1:0] a;
        ifc.req = m;
        for (int i = 0; i < n; i++) begin
            w = pick(m, mptr);
            a = addr_of(w);
            gq.push_back('{w, a});
            rq.push_back('{w, regs[a]});
            mptr = w + 2'd1;
        end
    endtask

    // One clock cycle: score a handshake that the coming edge will take,
    // then move to the next falling edge and score any grant.
    task automatic step();
        gexp_t g;
        rexp_t r;
        if (!rst && ifc.resp_valid && ifc.resp_ready) begin
            if (rq.size() == 0) begin
                check("resp_unexpected", 32'(ifc.resp_valid), 32'd0);
            end else begin
                r = rq.pop_front();
                check("resp_id", 32'(ifc.resp_id), 32'(r.id));
                check("resp_data", 32'(ifc.resp_data), 32'(r.data));
                $display("resp id=%0d data=%0h", ifc.resp_id, ifc.resp_data);
            end
        end
        @(negedge clk);
        cyc++;
        if (!rst && ifc.gnt != 4'd0) begin
            gnt_cnt++;
            if (gq.size() == 0) begin
                check("gnt_unexpected", 32'(ifc.gnt), 32'd0);
            end else begin
                g = gq.pop_front();
                check("gnt", 32'(ifc.gnt), 32'd1 << g.id);
                check("rd_sel", 32'(ifc.rd_sel), 32'(g.addr));
                $display("grant gnt=%b rd_sel=%0d", ifc.gnt, ifc.rd_sel);
            end
            if (spacing_en && last_gnt_cyc >= 0)
                check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'd3);
            last_gnt_cyc = cyc;
            if (auto_drop) ifc.req = ifc.req & ~ifc.gnt;
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) ifc.req = '0;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((gq.size() != 0 || rq.size() != 0 || ifc.busy) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(gq.size() + rq.size()), 32'd0);
        check({tag, "_idle"}, 32'(ifc.busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.req = '0;
        gq.delete();
        rq.delete();
        mptr = 2'd0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int n;
        int g0;
        regs[0] = 4'h5;
        regs[1] = 4'h3;
        regs[2] = 4'hA;
        regs[3] = 4'hC;
        // req3->1, req2->3, req1->0, req0->2
        ifc.req_addr   = {2'd1, 2'd3, 2'd0, 2'd2};
        ifc.req        = '0;
        ifc.resp_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_gnt", 32'(ifc.gnt), 32'd0);
        check("rst_rd_sel", 32'(ifc.rd_sel), 32'd0);
        check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        check("rst_resp_id", 32'(ifc.resp_id), 32'd0);
        check("rst_resp_data", 32'(ifc.resp_data), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        do_reset();

        // Single request, latency and data capture.
        post(4'b0001);
        step();
        check("t2_gnt", 32'(ifc.gnt), 32'b0001);
        check("t2_rd_sel", 32'(ifc.rd_sel), 32'd2);
        step();
        check("t2_valid", 32'(ifc.resp_valid), 32'd1);
        check("t2_id", 32'(ifc.resp_id), 32'd0);
        check("t2_data", 32'(ifc.resp_data), 32'hA);
        wait_done("t2", 20);

        // All requesters held: order 0,1,2,3,0 at 3-cycle spacing.
        do_reset();
        auto_drop    = 1'b0;
        spacing_en   = 1'b1;
        last_gnt_cyc = -1;
        hold_cnt     = 5;
        post_held(4'b1111, 5);
        wait_done("t3", 40);
        spacing_en = 1'b0;
        auto_drop  = 1'b1;

        // Consumer stalls five cycles while others wait.
        ifc.resp_ready = 1'b0;
        post(4'b0001);
        g0 = gnt_cnt;
        n  = 0;
        while (gnt_cnt == g0 && n < 20) begin step(); n++; end
        check("t4_gnt_seen", 32'(gnt_cnt - g0), 32'd1);
        post(4'b0110);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_valid_hold", 32'(ifc.resp_valid), 32'd1);
            check("t4_id_hold", 32'(ifc.resp_id), 32'd0);
            check("t4_data_hold", 32'(ifc.resp_data), 32'(regs[2]));
            check("t4_no_gnt", 32'(ifc.gnt), 32'd0);
        end
        ifc.resp_ready = 1'b1;
        wait_done("t4", 40);

        // Wrap from requester 3 back to 0.
        post(4'b1000);
        wait_done("t5a", 20);
        post(4'b1001);
        wait_done("t5b", 30);

        // Requester 0 drops its request during READ; next scan starts at 1.
        post(4'b0001);
        wait_done("t6a", 20);
        post(4'b0011);
        wait_done("t6b", 30);

        // Reset while a response is pending.
        ifc.resp_ready = 1'b0;
        post(4'b0001);
        n = 0;
        while (!ifc.resp_valid && n < 20) begin step(); n++; end
        check("t1_valid_before", 32'(ifc.resp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t1_gnt", 32'(ifc.gnt), 32'd0);
        check("t1_rd_sel", 32'(ifc.rd_sel), 32'd0);
        check("t1_valid", 32'(ifc.resp_valid), 32'd0);
        check("t1_id", 32'(ifc.resp_id), 32'd0);
        check("t1_data", 32'(ifc.resp_data), 32'd0);
        check("t1_busy", 32'(ifc.busy), 32'd0);
        gq.delete();
        rq.delete();
        mptr = 2'd0;
        ifc.req = '0;
        step();
        step();
        rst = 1'b0;
        ifc.resp_ready = 1'b1;
        g0 = gnt_cnt;
        for (int i = 0; i < 6; i++) step();
        check("t1_no_grant", 32'(gnt_cnt - g0), 32'd0);
        check("t1_idle", 32'(ifc.busy), 32'd0);
        check("t1_no_valid", 32'(ifc.resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
